// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg
// Shared definitions for the NPC core sequencer: state encodings, the default
// fetch/LSU watchdog limit, and a helper that identifies the handshake wait
// states that the optional watchdog (CORE_CTRL_TIMEOUT_EN) supervises.
package core_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RST   = 3'd0,
        ST_FETCH = 3'd1,
        ST_IWAIT = 3'd2,
        ST_EXEC  = 3'd3,
        ST_MREQ  = 3'd4,
        ST_MWAIT = 3'd5,
        ST_WB    = 3'd6,
        ST_HALT  = 3'd7
    } state_e;

    localparam int TIMEOUT_CYCLES_DEFAULT = 255;

    function automatic logic is_wait_state(state_e s);
        return (s == ST_FETCH) || (s == ST_IWAIT) || (s == ST_MREQ) || (s == ST_MWAIT);
    endfunction

endpackage

// File: rtl/core_ctrl_if.sv
// core_ctrl_if
// Fetch and load/store handshake bundle between the core sequencer and the
// instruction memory / LSU.
//   master : the sequencer (drives request valids and response readies)
//   slave  : instruction memory + LSU (drive request readies and response valids)
interface core_ctrl_if;

    logic if_req_valid;
    logic if_req_ready;
    logic if_resp_valid;
    logic if_resp_ready;
    logic ls_req_valid;
    logic ls_req_ready;
    logic ls_resp_valid;
    logic ls_resp_ready;

    modport master (
        output if_req_valid,
        input  if_req_ready,
        input  if_resp_valid,
        output if_resp_ready,
        output ls_req_valid,
        input  ls_req_ready,
        input  ls_resp_valid,
        output ls_resp_ready
    );

    modport slave (
        input  if_req_valid,
        output if_req_ready,
        output if_resp_valid,
        input  if_resp_ready,
        input  ls_req_valid,
        output ls_req_ready,
        output ls_resp_valid,
        input  ls_resp_ready
    );

endinterface

// File: rtl/bus_watchdog.sv
// bus_watchdog
// Counts consecutive cycles the sequencer spends in one handshake wait state
// and flags expiry on the LIMIT-th such cycle. Only built when
// CORE_CTRL_TIMEOUT_EN is defined; otherwise this file is empty.
// Ports:
//   clk, rst_n  core clock, async active-low reset
//   clear       first cycle of a newly entered state (count restarts here)
//   count_en    current state is a supervised wait state
//   expired     this cycle is the LIMIT-th cycle in the current wait state
`ifdef CORE_CTRL_TIMEOUT_EN
module bus_watchdog
    import core_ctrl_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int W = ($clog2(LIMIT + 1) > 8) ? $clog2(LIMIT + 1) : 8;

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_eff;

    // cnt_eff = cycles already spent in this state before the current one
    assign cnt_eff = clear ? '0 : cnt;
    assign expired = count_en && (cnt_eff >= W'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (count_en) begin
            cnt <= cnt_eff + W'(1);
        end else begin
            cnt <= '0;
        end
    end

endmodule
`endif

// File: rtl/core_ctrl.sv
// core_ctrl
// Multicycle sequencer for the NPC single-issue core. Walks each instruction
// through fetch, decode/execute, an optional LSU phase and writeback, and
// stops for good on ebreak.
// Ports:
//   clk, rst_n                  core clock, async active-low reset
//   bus (core_ctrl_if.master)   fetch and LSU handshakes
//   dec_*                       decoder outputs, sampled in EXEC
//   br_taken                    execute result for jumps/branches
//   inst_en                     instruction register load strobe
//   rf_wen, pc_wen, pc_sel_jump writeback strobes
//   halt                        sticky stop (ebreak or watchdog)
//   bus_err                     sticky watchdog expiry
//   retire_cnt                  retired-instruction counter, wraps
// Build option CORE_CTRL_TIMEOUT_EN: adds bus_watchdog, which sends the FSM to
// HALT with bus_err set after TIMEOUT_CYCLES cycles in one wait state.
// Without it bus_err stays 0 and waits are unbounded.
//
// state | meaning
// RST   | first cycle after reset release
// FETCH | fetch request raised, waiting for if_req_ready
// IWAIT | waiting for instruction word, loads IR on if_resp_valid
// EXEC  | decoder outputs valid, choose HALT / MREQ / WB
// MREQ  | LSU request raised, waiting for ls_req_ready
// MWAIT | waiting for LSU response
// WB    | one-cycle register/PC write, instruction retires
// HALT  | terminal, only reset leaves
module core_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int DATA_LEN       = 32,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    core_ctrl_if.master         bus,
    input  logic                dec_is_load,
    input  logic                dec_is_store,
    input  logic                dec_dest_wen,
    input  logic                dec_jump,
    input  logic                dec_ebreak,
    input  logic                br_taken,
    output logic                inst_en,
    output logic                rf_wen,
    output logic                pc_wen,
    output logic                pc_sel_jump,
    output logic                halt,
    output logic                bus_err,
    output logic [DATA_LEN-1:0] retire_cnt
);

    state_e state;
    logic   wd_clear;
    logic   wd_expired;

`ifdef CORE_CTRL_TIMEOUT_EN
    logic wd_count_en;

    assign wd_count_en = is_wait_state(state);

    bus_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_bus_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (wd_clear),
        .count_en (wd_count_en),
        .expired  (wd_expired)
    );
`else
    logic unused_timeout;

    assign wd_expired     = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES != 0) | wd_clear;
`endif

    // A completed handshake wins over a watchdog expiry in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RST;
            halt       <= 1'b0;
            bus_err    <= 1'b0;
            retire_cnt <= '0;
            wd_clear   <= 1'b0;
        end else begin
            wd_clear <= 1'b0;
            unique case (state)
                ST_RST: begin
                    state    <= ST_FETCH;
                    wd_clear <= 1'b1;
                end
                ST_FETCH: begin
                    if (bus.if_req_ready) begin
                        state    <= ST_IWAIT;
                        wd_clear <= 1'b1;
                    end else if (wd_expired) begin
                        state   <= ST_HALT;
                        halt    <= 1'b1;
                        bus_err <= 1'b1;
                    end
                end
                ST_IWAIT: begin
                    if (bus.if_resp_valid) begin
                        state <= ST_EXEC;
                    end else if (wd_expired) begin
                        state   <= ST_HALT;
                        halt    <= 1'b1;
                        bus_err <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (dec_ebreak) begin
                        state      <= ST_HALT;
                        halt       <= 1'b1;
                        retire_cnt <= retire_cnt + DATA_LEN'(1);
                    end else if (dec_is_load || dec_is_store) begin
                        state    <= ST_MREQ;
                        wd_clear <= 1'b1;
                    end else begin
                        state <= ST_WB;
                    end
                end
                ST_MREQ: begin
                    if (bus.ls_req_ready) begin
                        state    <= ST_MWAIT;
                        wd_clear <= 1'b1;
                    end else if (wd_expired) begin
                        state   <= ST_HALT;
                        halt    <= 1'b1;
                        bus_err <= 1'b1;
                    end
                end
                ST_MWAIT: begin
                    if (bus.ls_resp_valid) begin
                        state <= ST_WB;
                    end else if (wd_expired) begin
                        state   <= ST_HALT;
                        halt    <= 1'b1;
                        bus_err <= 1'b1;
                    end
                end
                ST_WB: begin
                    state      <= ST_FETCH;
                    wd_clear   <= 1'b1;
                    retire_cnt <= retire_cnt + DATA_LEN'(1);
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
            endcase
        end
    end

    // Handshake outputs and strobes decode straight from the state register.
    assign bus.if_req_valid  = (state == ST_FETCH);
    assign bus.if_resp_ready = (state == ST_IWAIT);
    assign bus.ls_req_valid  = (state == ST_MREQ);
    assign bus.ls_resp_ready = (state == ST_MWAIT);

    assign inst_en     = (state == ST_IWAIT) && bus.if_resp_valid;
    assign pc_wen      = (state == ST_WB);
    assign rf_wen      = (state == ST_WB) && dec_dest_wen;
    assign pc_sel_jump = (state == ST_WB) && dec_jump && br_taken;

endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl
// Directed bench for core_ctrl. A small memory/LSU responder raises each
// ready/valid after a programmable number of stall cycles; each scenario task
// compares cycle positions and strobe values against hand-computed numbers.
// Cycle 1 of an instruction is the first FETCH cycle.
module tb_core_ctrl;

    localparam int DL     = 4;
    localparam int TB_TO  = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    core_ctrl_if bus ();

    logic          dec_is_load, dec_is_store, dec_dest_wen, dec_jump, dec_ebreak, br_taken;
    logic          inst_en, rf_wen, pc_wen, pc_sel_jump, halt, bus_err;
    logic [DL-1:0] retire_cnt;

    core_ctrl #(
        .DATA_LEN       (DL),
        .TIMEOUT_CYCLES (TB_TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus.master),
        .dec_is_load  (dec_is_load),
        .dec_is_store (dec_is_store),
        .dec_dest_wen (dec_dest_wen),
        .dec_jump     (dec_jump),
        .dec_ebreak   (dec_ebreak),
        .br_taken     (br_taken),
        .inst_en      (inst_en),
        .rf_wen       (rf_wen),
        .pc_wen       (pc_wen),
        .pc_sel_jump  (pc_sel_jump),
        .halt         (halt),
        .bus_err      (bus_err),
        .retire_cnt   (retire_cnt)
    );

    int errors = 0;
    int checks = 0;

    // responder stall settings
    int rq_dly, rsp_dly, lrq_dly, lrsp_dly;
    bit resp_early;

    // results of the last run_inst
    int            r_wb, r_halt, r_lreq_hi, r_inst_en;
    logic          r_rf, r_pcsel;
    logic [DL-1:0] r_cnt1;

    task automatic zero_inputs();
        bus.if_req_ready  = 1'b0;
        bus.if_resp_valid = 1'b0;
        bus.ls_req_ready  = 1'b0;
        bus.ls_resp_valid = 1'b0;
        dec_is_load  = 1'b0;
        dec_is_store = 1'b0;
        dec_dest_wen = 1'b0;
        dec_jump     = 1'b0;
        dec_ebreak   = 1'b0;
        br_taken     = 1'b0;
        rq_dly = 0; rsp_dly = 0; lrq_dly = 0; lrsp_dly = 0; resp_early = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        zero_inputs();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Runs one instruction from the next clock edge (which must enter FETCH)
    // until WB or HALT is seen, bounded at 80 cycles.
    task automatic run_inst(input logic ld, input logic st, input logic dw,
                            input logic jmp, input logic brt, input logic eb);
        int fcnt = 0, rcnt = 0, lqcnt = 0, lrcnt = 0;
        r_wb = 0; r_halt = 0; r_lreq_hi = 0; r_inst_en = 0;
        r_rf = 1'bx; r_pcsel = 1'bx; r_cnt1 = 'x;
        dec_is_load = ld; dec_is_store = st; dec_dest_wen = dw;
        dec_jump = jmp; br_taken = brt; dec_ebreak = eb;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk);
            #1;
            bus.if_req_ready  = bus.if_req_valid && (fcnt >= rq_dly);
            bus.if_resp_valid = (bus.if_resp_ready && (rcnt >= rsp_dly)) ||
                                (resp_early && bus.if_req_valid);
            bus.ls_req_ready  = bus.ls_req_valid && (lqcnt >= lrq_dly);
            bus.ls_resp_valid = bus.ls_resp_ready && (lrcnt >= lrsp_dly);
            #1;
            if (c == 1) r_cnt1 = retire_cnt;
            if (bus.if_req_valid)  fcnt++;
            if (bus.if_resp_ready) rcnt++;
            if (bus.ls_req_valid)  begin lqcnt++; r_lreq_hi++; end
            if (bus.ls_resp_ready) lrcnt++;
            if (inst_en) r_inst_en++;
            if (pc_wen) begin
                r_wb = c; r_rf = rf_wen; r_pcsel = pc_sel_jump;
                break;
            end
            if (halt) begin
                r_halt = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [10+DL:0] outs;
        rst_n = 1'b0;
        bus.if_req_ready = 1'b1; bus.if_resp_valid = 1'b1;
        bus.ls_req_ready = 1'b1; bus.ls_resp_valid = 1'b1;
        dec_is_load = 1'b1; dec_is_store = 1'b1; dec_dest_wen = 1'b1;
        dec_jump = 1'b1; br_taken = 1'b1; dec_ebreak = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        outs = {bus.if_req_valid, bus.if_resp_ready, bus.ls_req_valid, bus.ls_resp_ready,
                inst_en, rf_wen, pc_wen, pc_sel_jump, halt, bus_err, 1'b0, retire_cnt};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %b expected all zero", outs); end
        zero_inputs();
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.if_req_valid !== 1'b0) begin errors++; $display("FAIL reset_rst_state_req: got %b expected 0", bus.if_req_valid); end
        @(posedge clk);
        #2;
        checks++;
        if (bus.if_req_valid !== 1'b1) begin errors++; $display("FAIL reset_first_fetch: got %b expected 1", bus.if_req_valid); end
        checks++;
        if (bus.if_resp_ready !== 1'b0) begin errors++; $display("FAIL reset_first_fetch_resp_rdy: got %b expected 0", bus.if_resp_ready); end
    endtask

    task automatic test_alu();
        do_reset();
        run_inst(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (r_wb !== 4) begin errors++; $display("FAIL alu_wb_cycle: got %0d expected 4", r_wb); end
        checks++; if (r_rf !== 1'b1) begin errors++; $display("FAIL alu_rf_wen: got %b expected 1", r_rf); end
        checks++; if (r_pcsel !== 1'b0) begin errors++; $display("FAIL alu_pc_sel: got %b expected 0", r_pcsel); end
        checks++; if (r_inst_en !== 1) begin errors++; $display("FAIL alu_inst_en_cycles: got %0d expected 1", r_inst_en); end
        checks++; if (r_lreq_hi !== 0) begin errors++; $display("FAIL alu_ls_req: got %0d expected 0", r_lreq_hi); end
        @(posedge clk); #2;
        checks++; if (retire_cnt !== 4'd1) begin errors++; $display("FAIL alu_retire: got %0d expected 1", retire_cnt); end
        checks++; if (pc_wen !== 1'b0) begin errors++; $display("FAIL alu_pc_wen_one_cycle: got %b expected 0", pc_wen); end
    endtask

    task automatic test_fetch_stall();
        do_reset();
        rq_dly = 2; rsp_dly = 1; resp_early = 1'b1;
        run_inst(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (r_wb !== 7) begin errors++; $display("FAIL fetch_stall_wb_cycle: got %0d expected 7", r_wb); end
        checks++; if (r_inst_en !== 1) begin errors++; $display("FAIL fetch_stall_inst_en: got %0d expected 1", r_inst_en); end
    endtask

    task automatic test_load_stall();
        do_reset();
        lrq_dly = 3; lrsp_dly = 2;
        run_inst(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (r_wb !== 11) begin errors++; $display("FAIL load_wb_cycle: got %0d expected 11", r_wb); end
        checks++; if (r_lreq_hi !== 4) begin errors++; $display("FAIL load_ls_req_cycles: got %0d expected 4", r_lreq_hi); end
        checks++; if (r_rf !== 1'b1) begin errors++; $display("FAIL load_rf_wen: got %b expected 1", r_rf); end
    endtask

    task automatic test_store_branch();
        do_reset();
        run_inst(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (r_wb !== 6) begin errors++; $display("FAIL store_wb_cycle: got %0d expected 6", r_wb); end
        checks++; if (r_rf !== 1'b0) begin errors++; $display("FAIL store_rf_wen: got %b expected 0", r_rf); end
        run_inst(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++; if (r_wb !== 4) begin errors++; $display("FAIL beq_wb_cycle: got %0d expected 4", r_wb); end
        checks++; if (r_pcsel !== 1'b1) begin errors++; $display("FAIL beq_pc_sel: got %b expected 1", r_pcsel); end
        checks++; if (r_rf !== 1'b0) begin errors++; $display("FAIL beq_rf_wen: got %b expected 0", r_rf); end
        run_inst(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (r_pcsel !== 1'b0) begin errors++; $display("FAIL bne_untaken_pc_sel: got %b expected 0", r_pcsel); end
        checks++; if (r_cnt1 !== 4'd2) begin errors++; $display("FAIL store_beq_retire: got %0d expected 2", r_cnt1); end
        run_inst(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        checks++; if ({r_rf, r_pcsel} !== 2'b11) begin errors++; $display("FAIL jal_rf_pcsel: got %b expected 11", {r_rf, r_pcsel}); end
        @(posedge clk); #2;
        checks++; if (retire_cnt !== 4'd4) begin errors++; $display("FAIL branch_seq_retire: got %0d expected 4", retire_cnt); end
    endtask

    task automatic test_ebreak();
        int act = 0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_inst(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            checks++; if (r_wb !== 4) begin errors++; $display("FAIL b2b_alu_wb_cycle[%0d]: got %0d expected 4", i, r_wb); end
        end
        run_inst(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (r_halt !== 4) begin errors++; $display("FAIL ebreak_halt_cycle: got %0d expected 4", r_halt); end
        checks++; if (retire_cnt !== 4'd6) begin errors++; $display("FAIL ebreak_retire: got %0d expected 6", retire_cnt); end
        bus.if_req_ready = 1'b1; bus.if_resp_valid = 1'b1;
        bus.ls_req_ready = 1'b1; bus.ls_resp_valid = 1'b1;
        dec_dest_wen = 1'b1; dec_ebreak = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #2;
            if (bus.if_req_valid || bus.ls_req_valid || inst_en || pc_wen || rf_wen || !halt) act++;
        end
        checks++; if (act !== 0) begin errors++; $display("FAIL halt_idle_activity: got %0d cycles expected 0", act); end
        checks++; if (retire_cnt !== 4'd6) begin errors++; $display("FAIL halt_retire_stable: got %0d expected 6", retire_cnt); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL ebreak_bus_err: got %b expected 0", bus_err); end
    endtask

    task automatic test_reset_mid();
        logic [9:0] outs;
        do_reset();
        run_inst(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        lrsp_dly = 1000;
        run_inst(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (r_cnt1 !== 4'd1) begin errors++; $display("FAIL mid_pre_retire: got %0d expected 1", r_cnt1); end
        checks++; if (bus.ls_resp_ready !== 1'b1) begin errors++; $display("FAIL mid_in_mwait: got %b expected 1", bus.ls_resp_ready); end
        #2 rst_n = 1'b0;
        #1;
        outs = {bus.if_req_valid, bus.if_resp_ready, bus.ls_req_valid, bus.ls_resp_ready,
                inst_en, rf_wen, pc_wen, pc_sel_jump, halt, bus_err};
        checks++; if (outs !== '0) begin errors++; $display("FAIL mid_reset_outputs: got %b expected all zero", outs); end
        checks++; if (retire_cnt !== 4'd0) begin errors++; $display("FAIL mid_reset_retire: got %0d expected 0", retire_cnt); end
        zero_inputs();
        @(posedge clk);
        #2 rst_n = 1'b1;
        run_inst(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (r_wb !== 4) begin errors++; $display("FAIL mid_refetch_wb_cycle: got %0d expected 4", r_wb); end
        checks++; if (r_cnt1 !== 4'd0) begin errors++; $display("FAIL mid_refetch_retire: got %0d expected 0", r_cnt1); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 17; i++) run_inst(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (r_cnt1 !== 4'd0) begin errors++; $display("FAIL wrap_at_16: got %0d expected 0", r_cnt1); end
        @(posedge clk); #2;
        checks++; if (retire_cnt !== 4'd1) begin errors++; $display("FAIL wrap_at_17: got %0d expected 1", retire_cnt); end
    endtask

`ifdef CORE_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        rsp_dly = 1000;
        run_inst(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (r_halt !== 18) begin errors++; $display("FAIL timeout_halt_cycle: got %0d expected 18", r_halt); end
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL timeout_bus_err: got %b expected 1", bus_err); end
        checks++; if (r_wb !== 0) begin errors++; $display("FAIL timeout_no_wb: got %0d expected 0", r_wb); end
        checks++; if (retire_cnt !== 4'd0) begin errors++; $display("FAIL timeout_retire: got %0d expected 0", retire_cnt); end
    endtask
`else
    task automatic test_long_wait();
        do_reset();
        rsp_dly = 40;
        run_inst(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (r_wb !== 44) begin errors++; $display("FAIL long_wait_wb_cycle: got %0d expected 44", r_wb); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL long_wait_bus_err: got %b expected 0", bus_err); end
    endtask
`endif

    initial begin
        zero_inputs();
        test_reset();
        test_alu();
        test_fetch_stall();
        test_load_stall();
        test_store_branch();
        test_ebreak();
        test_reset_mid();
        test_wrap();
`ifdef CORE_CTRL_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
